mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter_if.sv | 30 +++
 rtl/mult_share_arbiter.sv | 124 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Bus between the two requesters, the arbiter and the shared 8x8 multiplier.
// slave: the arbiter's view; master: the requesters plus multiplier side.
interface mult_share_arbiter_if;
    logic        req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        rready0, rready1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [15:0] result;
    logic        err;
    logic        busy;
    logic        mult_start;
    logic [7:0]  mult_dataa, mult_datab;
    logic        mult_done;
    logic [15:0] mult_product;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, rready0, rready1,
        input  mult_done, mult_product,
        output gnt0, gnt1, rvalid0, rvalid1, result, err, busy,
        output mult_start, mult_dataa, mult_datab
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, rready0, rready1,
        output mult_done, mult_product,
        input  gnt0, gnt1, rvalid0, rvalid1, result, err, busy,
        input  mult_start, mult_dataa, mult_datab
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Two-requester arbiter in front of one shared sequential 8x8 multiplier.
// Ties alternate against the last granted requester (req0 wins the first).
// Optional feature: define MULT_ARB_WDOG_EN to add a WAIT-state watchdog that
// returns result 0 with err=1 after WDOG_CYCLES cycles without mult_done.
module mult_share_arbiter
`ifdef MULT_ARB_WDOG_EN
#(
    parameter int WDOG_CYCLES = 15
)
`endif
(
    input logic                 clk,
    input logic                 reset_a,
    mult_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_gnt;
    logic [15:0] result_q;
    logic [7:0]  dataa_q, datab_q;
    logic        owner_rready;
    logic        wdog_hit;

    // Only the current owner's rready can release RESP.
    assign owner_rready = owner ? bus.rready1 : bus.rready0;

`ifdef MULT_ARB_WDOG_EN
    logic [7:0] wdog_cnt;
    logic       err_q;

    // Hit on the last allowed WAIT cycle, so WAIT lasts exactly WDOG_CYCLES cycles.
    assign wdog_hit = (wdog_cnt == 8'(WDOG_CYCLES - 1));

    // Watchdog counter: cleared while entering WAIT, counts WAIT cycles without done.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            wdog_cnt <= 8'd0;
        else if (state == START)
            wdog_cnt <= 8'd0;
        else if (state == WAIT && !bus.mult_done && !wdog_hit)
            wdog_cnt <= wdog_cnt + 8'd1;
    end

    // err marks a timed-out response; mult_done in the same cycle wins.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            err_q <= 1'b0;
        else if (state == WAIT && !bus.mult_done && wdog_hit)
            err_q <= 1'b1;
        else if (state == RESP && state_nxt == IDLE)
            err_q <= 1'b0;
    end

    assign bus.err = err_q;
`else
    assign wdog_hit = 1'b0;
    assign bus.err  = 1'b0;
`endif

    // Next-state and arbitration decision.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nxt = START;
                    if (bus.req0 && bus.req1)
                        owner_nxt = ~last_gnt;
                    else
                        owner_nxt = bus.req1;
                end
            end
            START:   state_nxt = WAIT;
            WAIT:    if (bus.mult_done || wdog_hit) state_nxt = RESP;
            RESP:    if (owner_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, owner and tie-break history.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (state == RESP && owner_rready)
                last_gnt <= owner;
        end
    end

    // Operand capture at grant and result capture on completion/timeout.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            dataa_q  <= 8'd0;
            datab_q  <= 8'd0;
            result_q <= 16'd0;
        end else begin
            if (state == IDLE && state_nxt == START) begin
                dataa_q <= owner_nxt ? bus.a1 : bus.a0;
                datab_q <= owner_nxt ? bus.b1 : bus.b0;
            end
            if (state == WAIT && bus.mult_done)
                result_q <= bus.mult_product;
            else if (state == WAIT && wdog_hit)
                result_q <= 16'd0;
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.mult_start = (state == START);
    assign bus.gnt0       = (state == START) && !owner;
    assign bus.gnt1       = (state == START) &&  owner;
    assign bus.rvalid0    = (state == RESP)  && !owner;
    assign bus.rvalid1    = (state == RESP)  &&  owner;
    assign bus.result     = result_q;
    assign bus.mult_dataa = dataa_q;
    assign bus.mult_datab = datab_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, hand-written corner sequences,
// and randomized rounds against a transaction-level arbitration model.
module tb_mult_share_arbiter;
    typedef struct {
        logic        r0, r1;
        logic [7:0]  a0, b0, a1, b1;
        int          lat;     // multiplier latency in cycles after start
        int          rdy;     // cycles rready is withheld in RESP
        logic        late;    // raise the other request right after the grant
        logic        eowner;
        logic [15:0] eres;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_a = 1'b0;
    int   errs    = 0;
    int   checks  = 0;
    int   mult_lat = 0;
    bit   inj_done = 1'b0;

    mult_share_arbiter_if bus();

    mult_share_arbiter u_dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Multiplier model: done pulse mult_lat cycles after start; inj_done forces a stray pulse.
    initial begin
        int cnt;
        cnt = 0;
        bus.mult_done    = 1'b0;
        bus.mult_product = 16'd0;
        forever begin
            @(negedge clk);
            #1;
            bus.mult_done = 1'b0;
            if (!reset_a)
                cnt = 0;
            else if (bus.mult_start)
                cnt = mult_lat;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mult_done    = 1'b1;
                    bus.mult_product = {8'd0, bus.mult_dataa} * {8'd0, bus.mult_datab};
                end
            end
            if (inj_done) begin
                bus.mult_done    = 1'b1;
                bus.mult_product = 16'hDEAD;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_a = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.rready0 = 1'b0; bus.rready1 = 1'b0;
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
    endtask

    // One full transaction, starting and ending at a negedge with the arbiter idle.
    task automatic serve(input vec_t v, input string tag);
        int         n;
        logic       ok;
        logic [7:0] ea, eb;
        ea = v.eowner ? v.a1 : v.a0;
        eb = v.eowner ? v.b1 : v.b0;
        chk({tag, "_idle"}, {bus.busy, bus.gnt1, bus.gnt0}, 3'b000);
        bus.rready0 = 1'b0; bus.rready1 = 1'b0;
        bus.req0 = v.r0; bus.req1 = v.r1;
        bus.a0 = v.a0; bus.b0 = v.b0; bus.a1 = v.a1; bus.b1 = v.b1;
        mult_lat = v.lat;
        @(negedge clk);
        chk({tag, "_gnt"}, {bus.gnt1, bus.gnt0}, v.eowner ? 2'b10 : 2'b01);
        chk({tag, "_start"}, bus.mult_start, 1'b1);
        chk({tag, "_ops"}, {bus.mult_dataa, bus.mult_datab}, {ea, eb});
        if (v.eowner) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        if (v.late) begin
            if (v.eowner) bus.req0 = 1'b1; else bus.req1 = 1'b1;
        end
        n  = 0;
        ok = 1'b1;
        while (!(bus.rvalid0 || bus.rvalid1) && n < 64) begin
            @(negedge clk);
            n++;
            if (!(bus.rvalid0 || bus.rvalid1) &&
                (bus.mult_start || bus.gnt0 || bus.gnt1 || !bus.busy ||
                 bus.mult_dataa != ea || bus.mult_datab != eb))
                ok = 1'b0;
        end
        chk({tag, "_wait_stable"}, ok, 1'b1);
        chk({tag, "_latency"}, n, v.lat + 1);
        chk({tag, "_rvalid"}, {bus.rvalid1, bus.rvalid0}, v.eowner ? 2'b10 : 2'b01);
        chk({tag, "_result"}, bus.result, v.eres);
        chk({tag, "_err"}, bus.err, 1'b0);
        // Withhold the owner's rready; the other requester's rready must not count.
        if (v.eowner) bus.rready0 = 1'b1; else bus.rready1 = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < v.rdy; i++) begin
            inj_done = (i == 0);
            @(negedge clk);
            inj_done = 1'b0;
            if ({bus.rvalid1, bus.rvalid0} != (v.eowner ? 2'b10 : 2'b01) ||
                bus.result != v.eres || bus.gnt0 || bus.gnt1 ||
                bus.mult_dataa != ea || bus.mult_datab != eb)
                ok = 1'b0;
        end
        chk({tag, "_hold"}, ok, 1'b1);
        if (v.eowner) bus.rready1 = 1'b1; else bus.rready0 = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {bus.busy, bus.rvalid1, bus.rvalid0, bus.gnt1, bus.gnt0}, 5'b0);
        bus.rready0 = 1'b0; bus.rready1 = 1'b0;
    endtask

    initial begin
        vec_t       tbl[7];
        vec_t       v;
        bit         pend[2];
        logic [7:0] pa[2], pb[2];
        logic       last, w;
        int         n, q;
        logic       ok;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 8'd0; bus.b0 = 8'd0; bus.a1 = 8'd0; bus.b1 = 8'd0;
        bus.rready0 = 1'b0; bus.rready1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        chk("rst_result", bus.result, 16'd0);
        chk("rst_ops", {bus.mult_dataa, bus.mult_datab}, 16'd0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_start", bus.mult_start, 1'b0);
        reset_a = 1'b1;
        @(negedge clk);
        chk("idle_no_req", {bus.busy, bus.mult_start}, 2'b00);

        //           r0 r1 a0     b0     a1     b1     lat rdy late own res
        tbl[0] = '{1, 0, 8'd12,  8'd11,  8'd0,   8'd0,   4, 0,  0,   0, 16'd132};
        tbl[1] = '{0, 1, 8'd0,   8'd0,   8'hFF,  8'hFF,  3, 2,  0,   1, 16'hFE01};
        tbl[2] = '{1, 1, 8'd3,   8'd5,   8'd7,   8'd9,   2, 1,  0,   0, 16'd15};
        tbl[3] = '{1, 1, 8'h10,  8'h11,  8'd2,   8'h80,  5, 0,  0,   1, 16'h0100};
        tbl[4] = '{1, 1, 8'd0,   8'hAB,  8'd1,   8'd1,   1, 3,  0,   0, 16'd0};
        tbl[5] = '{1, 0, 8'hFF,  8'd1,   8'h80,  8'd2,   6, 10, 1,   0, 16'h00FF};
        tbl[6] = '{0, 1, 8'hFF,  8'd1,   8'h80,  8'd2,   2, 0,  0,   1, 16'h0100};
        for (int i = 0; i < 7; i++)
            serve(tbl[i], $sformatf("vec%0d", i));
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Reset in the middle of WAIT, then a late done pulse after release
        bus.a0 = 8'd20; bus.b0 = 8'd3; mult_lat = 8; bus.req0 = 1'b1;
        @(negedge clk);
        chk("abort_gnt", bus.gnt0, 1'b1);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_wait", {bus.busy, bus.mult_start}, 2'b10);
        #2 reset_a = 1'b0;
        #1;
        chk("abort_ctl", {bus.busy, bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mult_start, bus.err}, 7'b0);
        chk("abort_result", bus.result, 16'd0);
        chk("abort_ops", {bus.mult_dataa, bus.mult_datab}, 16'd0);
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.rvalid0 || bus.rvalid1 || bus.gnt0 || bus.gnt1) ok = 1'b0;
        end
        chk("late_done_ignored", ok, 1'b1);
        v = '{1, 1, 8'd9, 8'd9, 8'd4, 8'd4, 2, 0, 0, 0, 16'd81};
        serve(v, "post_rst_tie");
        bus.req1 = 1'b0;

        // Multiplier that never finishes
        mult_lat = 0; bus.a1 = 8'd5; bus.b1 = 8'd6; bus.req1 = 1'b1;
        @(negedge clk);
        chk("hang_gnt", bus.gnt1, 1'b1);
        bus.req1 = 1'b0;
`ifdef MULT_ARB_WDOG_EN
        n = 0;
        while (!bus.rvalid1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_latency", n, 15 + 1);
        chk("wdog_err", bus.err, 1'b1);
        chk("wdog_result", bus.result, 16'd0);
        chk("wdog_rvalid0", bus.rvalid0, 1'b0);
        bus.rready1 = 1'b1;
        @(negedge clk);
        chk("wdog_release", {bus.busy, bus.err}, 2'b00);
        bus.rready1 = 1'b0;
`else
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!bus.busy || bus.err || bus.rvalid0 || bus.rvalid1) ok = 1'b0;
        end
        chk("hang_stays_busy", ok, 1'b1);
        chk("hang_err", bus.err, 1'b0);
        do_reset();
`endif

        // Randomized rounds against a pending-request/alternation model
        do_reset();
        last = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) begin
                    pend[k] = 1'b1;
                    pa[k] = 8'($urandom);
                    pb[k] = 8'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                q = $urandom_range(1, 0);
                pend[q] = 1'b1;
                pa[q] = 8'($urandom);
                pb[q] = 8'($urandom);
            end
            w = (pend[0] && pend[1]) ? !last : pend[1];
            v = '{pend[0], pend[1], pa[0], pb[0], pa[1], pb[1],
                  $urandom_range(6, 1), $urandom_range(3, 0), 1'b0, w,
                  {8'd0, pa[w]} * {8'd0, pb[w]}};
            serve(v, $sformatf("rnd%0d", r));
            pend[w] = 1'b0;
            last = w;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
